icache_assoc: RTL

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 132 +++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with line refill FSM and round-robin victim choice.
// Define ICACHE_FLUSH_EN to add the flush port (invalidate-all, deferred to line completion during refill).
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        roll,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [31:0] if_inst,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_valid,
    input  logic [31:0] mc_data
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic        flush
`endif
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int OB = OW > 0 ? OW : 1;
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - OW - IW;
    localparam int WB = WAYS > 1 ? $clog2(WAYS) : 1;
    typedef enum logic [1:0] {IDLE, REFILL, HOLD} state_t;
    state_t state;
    logic [31:0] data_q [WAYS][SETS][LINE_WORDS];
    logic [TW-1:0] tag_q [WAYS][SETS];
    logic [SETS-1:0] valid_q [WAYS];
    logic [WB-1:0] rr_q [SETS];
    logic [31:0] buf_q [LINE_WORDS];
    logic [OB-1:0] cnt_q, off_q, pc_off;
    logic [IW-1:0] idx_q, pc_idx;
    logic [TW-1:0] tag_r, pc_tag;
    logic [WB-1:0] hit_way, vic;
    logic hit, fin, fl, fl_pend;
`ifdef ICACHE_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    assign pc_off = (OW == 0) ? '0 : OB'(if_pc >> 2);
    assign pc_idx = IW'(if_pc >> (OW + 2));
    assign pc_tag = TW'(if_pc >> (OW + 2 + IW));
    assign fin    = mc_valid && cnt_q == OB'(LINE_WORDS - 1);
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && valid_q[w][pc_idx] && tag_q[w][pc_idx] == pc_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        hit = hit && !fl;
    end
    // Lowest invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        vic = rr_q[idx_q];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[w][idx_q]) vic = WB'(w);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            if_ready <= 1'b0;
            if_inst  <= '0;
            mc_req   <= 1'b0;
            mc_addr  <= '0;
            cnt_q    <= '0;
            fl_pend  <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            if_ready <= 1'b0;
            if (rdy) begin
                if (roll) begin
                    state  <= IDLE;
                    mc_req <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    unique case (state)
                        IDLE: if (if_valid) begin
                            if (hit) begin
                                if_ready <= 1'b1;
                                if_inst  <= data_q[hit_way][pc_idx][pc_off];
                                state    <= HOLD;
                            end else begin
                                state   <= REFILL;
                                mc_req  <= 1'b1;
                                mc_addr <= if_pc & ~(32'(LINE_WORDS) * 32'd4 - 32'd1);
                                off_q   <= pc_off;
                                idx_q   <= pc_idx;
                                tag_r   <= pc_tag;
                            end
                        end
                        REFILL: if (mc_valid) begin
                            cnt_q <= fin ? '0 : cnt_q + OB'(1);
                            if (fin) begin
                                mc_req               <= 1'b0;
                                if_ready             <= 1'b1;
                                if_inst              <= off_q == cnt_q ? mc_data : buf_q[off_q];
                                state                <= HOLD;
                                valid_q[vic][idx_q]  <= 1'b1;
                                rr_q[idx_q]          <= (WAYS == 1) ? '0 : rr_q[idx_q] + WB'(1);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
                // A flush seen during refill is held until the line completes or is abandoned.
                if ((fl && state != REFILL) || ((fl || fl_pend) && state == REFILL && (roll || fin)))
                    for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                fl_pend <= state == REFILL && !roll && !fin && (fl || fl_pend);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && rdy && !roll && state == REFILL && mc_valid) begin
            buf_q[cnt_q] <= mc_data;
            if (fin) begin
                tag_q[vic][idx_q] <= tag_r;
                for (int i = 0; i < LINE_WORDS; i++)
                    data_q[vic][idx_q][i] <= OB'(i) == cnt_q ? mc_data : buf_q[i];
            end
        end
    end
endmodule
